// File: rtl/vga_text_pkg.sv
// Shared definitions for the VGA text-mode fetch path: font cell geometry,
// pipeline latency and the delay-line entry that travels alongside a pixel.
package vga_text_pkg;

    localparam int CHAR_W             = 8;
    localparam int CHAR_H             = 16;
    localparam int FONT_ADDR_W        = 12;
    localparam int TEXT_FETCH_LATENCY = 5;

    // Per-pixel side information carried down the fetch pipeline.
    typedef struct packed {
        logic       in_range;
        logic [2:0] x_lo;
        logic [3:0] y_lo;
    } tf_dl_t;

    localparam tf_dl_t TF_DL_ZERO = '{in_range: 1'b0, x_lo: 3'd0, y_lo: 4'd0};

    // The cursor is drawn as an underline on the bottom two font rows.
    function automatic logic is_cursor_line(input logic [3:0] y_lo);
        return (y_lo >= 4'd14);
    endfunction

endpackage

// File: rtl/text_cursor_blink.sv
// Cursor blink generator: counts frames, toggles the blink phase every
// BLINK_FRAMES frames and flags the pixels of the cursor underline.
// Only instantiated when TEXT_FETCH_CURSOR_EN is defined.
module text_cursor_blink
    import vga_text_pkg::*;
#(
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start_i,
    input  logic [6:0] col_i,
    input  logic [5:0] crow_i,
    input  logic [3:0] y_lo_i,
    input  logic [6:0] cursor_col_i,
    input  logic [4:0] cursor_row_i,
    output logic       hit_o
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             blink_q;
    logic             blink_d;

    // Next frame count and blink phase; advance only at the start of a frame.
    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (frame_start_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = {CNT_W{1'b0}};
                blink_d = ~blink_q;
            end else begin
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                blink_d = blink_q;
            end
        end else begin
            cnt_d   = cnt_q;
            blink_d = blink_q;
        end
    end

    // Frame counter and blink phase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= {CNT_W{1'b0}};
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign hit_o = blink_q
                 && (col_i == cursor_col_i)
                 && (crow_i == {1'b0, cursor_row_i})
                 && is_cursor_line(y_lo_i);

endmodule

// File: rtl/text_fetch.sv
// Character fetch pipeline for VGA text mode. Turns timing-generator pixel
// coordinates into a text-RAM read, then a font-ROM read, and presents the
// font row with its in-cell column exactly TEXT_FETCH_LATENCY clocks after
// the coordinates were sampled. Optional cursor underline with blink is
// enabled by defining TEXT_FETCH_CURSOR_EN.
module text_fetch
    import vga_text_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int ADDR_W       = 12,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   active,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_en,
    input  logic [7:0]             ram_data,
    output logic [FONT_ADDR_W-1:0] font_addr,
    input  logic [CHAR_W-1:0]      font_data,
    output logic [CHAR_W-1:0]      charline,
    output logic [2:0]             charpos_x,
    output logic                   pix_valid
`ifdef TEXT_FETCH_CURSOR_EN
    ,
    input  logic [6:0]             cursor_col,
    input  logic [4:0]             cursor_row
`endif
);

    // Stages after the input register: RAM read, font address, ROM read.
    localparam int DL_DEPTH = TEXT_FETCH_LATENCY - 1;

    if (COLS * ROWS > (2 ** ADDR_W)) begin : g_addr_chk
        $error("COLS*ROWS does not fit in ADDR_W bits");
    end
    if (BLINK_FRAMES < 1) begin : g_blink_chk
        $error("BLINK_FRAMES must be at least 1");
    end

    logic [6:0]             col_s;
    logic [5:0]             crow_s;
    logic                   in_range_s;
    tf_dl_t                 dl_in_s;

    logic [9:0]             y_q;
    logic [ADDR_W-1:0]      row_base_q;
    logic [ADDR_W-1:0]      row_base_d;
    logic [ADDR_W-1:0]      ram_addr_q;
    logic [ADDR_W-1:0]      ram_addr_d;
    logic                   ram_en_q;
    tf_dl_t [DL_DEPTH-1:0]  dl_q;
    logic [FONT_ADDR_W-1:0] font_addr_q;
    logic [CHAR_W-1:0]      charline_q;
    logic [CHAR_W-1:0]      charline_d;
    logic [2:0]             charpos_x_q;
    logic                   pix_valid_q;
    logic                   cursor_s;

    assign col_s      = x[9:3];
    assign crow_s     = y[9:4];
    assign in_range_s = active && (int'(col_s) < COLS) && (int'(crow_s) < ROWS);
    assign dl_in_s    = '{in_range: in_range_s, x_lo: x[2:0], y_lo: y[3:0]};

    // Row base follows y without a multiplier: clear on line 0, add one text
    // row on the first cycle of each new 16-line band. The updated value is
    // used for the same pixel so the first cell of a band gets the new row.
    always_comb begin
        row_base_d = row_base_q;
        if (y == 10'd0) begin
            row_base_d = {ADDR_W{1'b0}};
        end else if ((y != y_q) && (y[3:0] == 4'd0)) begin
            row_base_d = row_base_q + ADDR_W'(COLS);
        end else begin
            row_base_d = row_base_q;
        end
    end

    // Text-RAM address: only advance for visible cells, hold otherwise.
    always_comb begin
        ram_addr_d = ram_addr_q;
        if (in_range_s) begin
            ram_addr_d = row_base_d + ADDR_W'(col_s);
        end else begin
            ram_addr_d = ram_addr_q;
        end
    end

    // Row tracking and stage A (RAM request) registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q        <= 10'd0;
            row_base_q <= {ADDR_W{1'b0}};
            ram_addr_q <= {ADDR_W{1'b0}};
            ram_en_q   <= 1'b0;
        end else begin
            y_q        <= y;
            row_base_q <= row_base_d;
            ram_addr_q <= ram_addr_d;
            ram_en_q   <= in_range_s;
        end
    end

    // Delay line carrying range flag and in-cell coordinates to stage C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DL_DEPTH; i++) begin
                dl_q[i] <= TF_DL_ZERO;
            end
        end else begin
            dl_q[0] <= dl_in_s;
            for (int i = 1; i < DL_DEPTH; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    // Stage B: font address from the returned character code and its font row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            font_addr_q <= {FONT_ADDR_W{1'b0}};
        end else begin
            font_addr_q <= {ram_data, dl_q[1].y_lo};
        end
    end

`ifdef TEXT_FETCH_CURSOR_EN
    logic                cur_hit_s;
    logic                frame_start_s;
    logic [DL_DEPTH-1:0] cur_q;

    assign frame_start_s = (y == 10'd0) && (y_q != 10'd0);

    text_cursor_blink #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_cursor (
        .clk          (clk),
        .reset        (reset),
        .frame_start_i(frame_start_s),
        .col_i        (col_s),
        .crow_i       (crow_s),
        .y_lo_i       (y[3:0]),
        .cursor_col_i (cursor_col),
        .cursor_row_i (cursor_row),
        .hit_o        (cur_hit_s)
    );

    // Cursor hit travels alongside the pixel so it lands in stage C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q <= {DL_DEPTH{1'b0}};
        end else begin
            cur_q <= {cur_q[DL_DEPTH-2:0], cur_hit_s & in_range_s};
        end
    end

    assign cursor_s = cur_q[DL_DEPTH-1];
`else
    assign cursor_s = 1'b0;
`endif

    // Stage C data: cursor underline overrides, blank outside the text area.
    always_comb begin
        charline_d = 8'h00;
        if (cursor_s) begin
            charline_d = 8'hFF;
        end else if (dl_q[DL_DEPTH-1].in_range) begin
            charline_d = font_data;
        end else begin
            charline_d = 8'h00;
        end
    end

    // Stage C output registers, aligned with the delayed coordinates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            charline_q  <= 8'h00;
            charpos_x_q <= 3'd0;
            pix_valid_q <= 1'b0;
        end else begin
            charline_q  <= charline_d;
            charpos_x_q <= dl_q[DL_DEPTH-1].x_lo;
            pix_valid_q <= dl_q[DL_DEPTH-1].in_range;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_en    = ram_en_q;
    assign font_addr = font_addr_q;
    assign charline  = charline_q;
    assign charpos_x = charpos_x_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_text_fetch.sv
// Self-checking bench for text_fetch with behavioural text-RAM / font-ROM
// models and a per-pixel expectation queue. Cursor scenario is built when
// TEXT_FETCH_CURSOR_EN is defined.
module tb_text_fetch;
    import vga_text_pkg::*;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
`ifdef TEXT_FETCH_CURSOR_EN
    localparam int BLINK  = 2;
`else
    localparam int BLINK  = 32;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              active;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en;
    logic [7:0]        ram_data;
    logic [11:0]       font_addr;
    logic [7:0]        font_data;
    logic [7:0]        charline;
    logic [2:0]        charpos_x;
    logic              pix_valid;
`ifdef TEXT_FETCH_CURSOR_EN
    logic [6:0]        cursor_col = 7'd2;
    logic [4:0]        cursor_row = 5'd1;
`endif

    always #5 clk = ~clk;

    text_fetch #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLINK_FRAMES(BLINK)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .active(active),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_data(ram_data),
        .font_addr(font_addr), .font_data(font_data),
        .charline(charline), .charpos_x(charpos_x), .pix_valid(pix_valid)
`ifdef TEXT_FETCH_CURSOR_EN
        , .cursor_col(cursor_col), .cursor_row(cursor_row)
`endif
    );

    // Behavioural memories: synchronous text RAM with enable, free-running font ROM.
    logic [7:0] mem [0:4095];
    logic [7:0] rom [0:4095];

    always_ff @(posedge clk) begin
        if (ram_en) ram_data <= mem[ram_addr];
    end

    always_ff @(posedge clk) begin
        font_data <= rom[font_addr];
    end

    typedef struct {
        bit       in_r;
        bit [2:0] xlo;
        bit [3:0] ylo;
        bit       known;
        int       addr;
        bit [7:0] code;
        bit       cur;
    } exp_t;

    exp_t pq[$];
    int   total = 0;
    int   bad   = 0;
    bit   addr_known;
    bit   last_valid;
    int   last_addr;
    int   prev_y;
    int   frames;

    // Drive one pixel, advance one clock and check every pipeline stage.
    task automatic step(input int xi, input int yi, input bit act);
        exp_t e;
        exp_t c;
        int col, crow;
        logic [7:0] want_line;
        col    = xi / 8;
        crow   = yi / 16;
        e.in_r = act && (col < COLS) && (crow < ROWS);
        e.xlo  = 3'(xi % 8);
        e.ylo  = 4'(yi % 16);
        if (yi == 0) addr_known = 1'b1;
        e.known = addr_known;
        e.addr  = crow * COLS + col;
        e.code  = mem[e.addr % 4096];
        e.cur   = 1'b0;
`ifdef TEXT_FETCH_CURSOR_EN
        e.cur = e.in_r && (col == 2) && (crow == 1) && (e.ylo >= 4'd14)
                && (((frames / BLINK) % 2) == 1);
        if (yi == 0 && prev_y != 0) frames++;
`endif
        prev_y = yi;
        x      = 10'(xi);
        y      = 10'(yi);
        active = act;
        pq.push_back(e);
        @(posedge clk);
        #1;
        // Stage A: RAM request for this pixel
        total++;
        if (ram_en !== e.in_r) begin
            bad++;
            $display("FAIL ram_en x=%0d y=%0d: got %b want %b", xi, yi, ram_en, e.in_r);
        end
        if (e.in_r && e.known) begin
            last_addr  = e.addr;
            last_valid = 1'b1;
        end else if (e.in_r) begin
            last_valid = 1'b0;
        end
        if (last_valid) begin
            total++;
            if (ram_addr !== last_addr[ADDR_W-1:0]) begin
                bad++;
                $display("FAIL ram_addr x=%0d y=%0d: got %0d want %0d", xi, yi, ram_addr, last_addr);
            end
        end
        // Stage B: font address for the pixel sampled three clocks ago
        if (pq.size() >= 3) begin
            c = pq[pq.size() - 3];
            if (c.in_r && c.known) begin
                total++;
                if (font_addr !== {c.code, c.ylo}) begin
                    bad++;
                    $display("FAIL font_addr: got %h want %h", font_addr, {c.code, c.ylo});
                end
            end
        end
        // Stage C: outputs for the pixel sampled five clocks ago
        if (pq.size() == TEXT_FETCH_LATENCY) begin
            c = pq.pop_front();
            total++;
            if (pix_valid !== c.in_r) begin
                bad++;
                $display("FAIL pix_valid: got %b want %b", pix_valid, c.in_r);
            end
            total++;
            if (charpos_x !== c.xlo) begin
                bad++;
                $display("FAIL charpos_x: got %0d want %0d", charpos_x, c.xlo);
            end
            if (c.known || !c.in_r || c.cur) begin
                if (c.cur) want_line = 8'hFF;
                else if (c.in_r) want_line = rom[{c.code, c.ylo}];
                else want_line = 8'h00;
                total++;
                if (charline !== want_line) begin
                    bad++;
                    $display("FAIL charline: got %h want %h", charline, want_line);
                end
            end
        end else begin
            total++;
            if (pix_valid !== 1'b0) begin
                bad++;
                $display("FAIL pix_valid_fill: got %b want 0", pix_valid);
            end
        end
    endtask

    task automatic model_clear();
        pq.delete();
        addr_known = 1'b1;
        last_valid = 1'b1;
        last_addr  = 0;
        prev_y     = 0;
        frames     = 0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        x      = 10'd0;
        y      = 10'd0;
        active = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic flush();
        for (int i = 0; i < TEXT_FETCH_LATENCY; i++) step(0, 0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({ram_addr, ram_en, font_addr, charline, charpos_x, pix_valid} !== '0) begin
            bad++;
            $display("FAIL %s: got ram_addr=%h ram_en=%b font_addr=%h charline=%h charpos_x=%0d pix_valid=%b want all 0",
                     tag, ram_addr, ram_en, font_addr, charline, charpos_x, pix_valid);
        end
    endtask

    task automatic test_reset();
        #3;
        check_all_zero("reset_state");
        do_reset();
    endtask

    task automatic test_first_pixel();
        mem[0]      = 8'h41;
        rom[12'h410] = 8'h18;
        do_reset();
        step(0, 0, 1'b1);
        total++;
        if (ram_addr !== 12'd0 || ram_en !== 1'b1) begin
            bad++;
            $display("FAIL first_ram: got addr=%0d en=%b want 0 1", ram_addr, ram_en);
        end
        step(1, 0, 1'b1);
        step(2, 0, 1'b1);
        total++;
        if (font_addr !== 12'h410) begin
            bad++;
            $display("FAIL first_font_addr: got %h want 410", font_addr);
        end
        step(3, 0, 1'b1);
        step(4, 0, 1'b1);
        total++;
        if (charline !== 8'h18 || charpos_x !== 3'd0 || pix_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_out: got %h %0d %b want 18 0 1", charline, charpos_x, pix_valid);
        end
        flush();
    endtask

    task automatic test_row_base();
        do_reset();
        for (int yy = 0; yy < 15; yy++) step(0, yy, 1'b1);
        step(8, 15, 1'b1);
        step(8, 16, 1'b1);
        total++;
        if (ram_addr !== 12'd81) begin
            bad++;
            $display("FAIL row_base_16: got %0d want 81", ram_addr);
        end
        for (int yy = 17; yy <= 32; yy++) step(0, yy, 1'b1);
        total++;
        if (ram_addr !== 12'd160) begin
            bad++;
            $display("FAIL row_base_32: got %0d want 160", ram_addr);
        end
        step(0, 0, 1'b1);
        total++;
        if (ram_addr !== 12'd0) begin
            bad++;
            $display("FAIL row_base_0: got %0d want 0", ram_addr);
        end
        flush();
    endtask

    task automatic test_out_of_range();
        do_reset();
        step(16, 0, 1'b1);
        step(640, 0, 1'b1);
        step(700, 0, 1'b1);
        step(24, 0, 1'b0);
        step(0, 480, 1'b1);
        step(100, 480, 1'b1);
        step(0, 0, 1'b1);
        flush();
    endtask

    task automatic test_stream();
        do_reset();
        for (int xx = 0; xx < 16; xx++) step(xx, 0, 1'b1);
        flush();
    endtask

    task automatic test_random_frame();
        int n;
        do_reset();
        for (int yy = 0; yy < 525; yy++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++)
                step($urandom_range(0, 700), yy, ($urandom_range(0, 7) != 0));
        end
        flush();
    endtask

    task automatic test_mid_reset();
        do_reset();
        addr_known = 1'b0;
        last_valid = 1'b0;
        for (int i = 0; i < 3; i++) step(300 + i, 200, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        addr_known = 1'b0;
        last_valid = 1'b0;
        step(300, 200, 1'b1);
        total++;
        if (ram_addr !== 12'd37) begin
            bad++;
            $display("FAIL post_reset_base: got %0d want 37", ram_addr);
        end
        for (int i = 1; i < 8; i++) step(300 + i, 200, 1'b1);
        step(0, 0, 1'b1);
        step(8, 0, 1'b1);
        flush();
    endtask

`ifdef TEXT_FETCH_CURSOR_EN
    task automatic test_cursor();
        do_reset();
        step(0, 1, 1'b1);
        step(0, 0, 1'b1);
        step(0, 1, 1'b1);
        step(0, 0, 1'b1);
        for (int yy = 1; yy < 32; yy++)
            for (int xx = 8; xx < 32; xx++) step(xx, yy, 1'b1);
        flush();
    endtask
`endif

    initial begin
        reset  = 1'b1;
        x      = 10'd0;
        y      = 10'd0;
        active = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'($urandom);
            rom[i] = 8'($urandom);
        end
        model_clear();
        test_reset();
        test_first_pixel();
        test_row_base();
        test_out_of_range();
        test_stream();
        test_random_frame();
        test_mid_reset();
`ifdef TEXT_FETCH_CURSOR_EN
        test_cursor();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
